dmi_unlock_ctrl: RTL and testbench

//   Sequences the JTAG debug-unlock flow on the TCK domain. Collects password words from the DMI

---
 rtl/dmi_unlock_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dmi_unlock_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_unlock_ctrl.sv
// rtl/dmi_unlock_ctrl.sv - JTAG debug-unlock sequencer (optional auto-relock via DMI_UNLOCK_RELOCK_EN)
module dmi_unlock_ctrl #(
    parameter int unsigned PW_WORDS       = 2,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned RELOCK_CYCLES  = 65536
) (
    input  logic         tck_i,
    input  logic         trst_ni,
    input  logic         pw_valid_i,
    input  logic [31:0]  pw_data_i,
    output logic         pw_ready_o,
    output logic         hash_init_o,
    input  logic         hash_ready_i,
    input  logic         hash_valid_i,
    input  logic [255:0] hash_i,
    input  logic [255:0] exp_hash_i,
    output logic [511:0] message_o,
    input  logic         relock_i,
    output logic         unlock_o,
    output logic         lockout_o,
    output logic [3:0]   fail_cnt_o,
    output logic         busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_START_ACK,
        S_WAIT_HASH,
        S_LOCKOUT
    } state_t;

    localparam int unsigned    IDX_W    = (PW_WORDS > 1) ? $clog2(PW_WORDS) : 1;
    localparam int unsigned    LK_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_WORDS - 1);
    localparam logic [LK_W-1:0]  LK_LOAD  = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       FAIL_MAX = 4'(MAX_FAILS);

    if (PW_WORDS < 1 || PW_WORDS > 16 || MAX_FAILS < 1 || MAX_FAILS > 15 ||
        LOCKOUT_CYCLES < 1 || RELOCK_CYCLES < 1 || RELOCK_CYCLES > 131072) begin : g_param_check
        $error("dmi_unlock_ctrl: parameter out of range");
    end

    state_t            state_q, state_d;
    logic              init_q, init_d;
    logic [IDX_W-1:0]  idx_q;
    logic [511:0]      msg_q;
    logic              unlock_q;
    logic [3:0]        fail_q;
    logic [LK_W-1:0]   lk_q;
    logic              rl_expire;

    logic       pw_fire;
    logic       hash_done;
    logic       hash_match;
    logic [3:0] fail_inc;
    logic       enter_lockout;

    assign pw_fire       = pw_valid_i && (state_q == S_IDLE);
    assign hash_done     = hash_valid_i && (state_q == S_WAIT_HASH);
    assign hash_match    = (hash_i == exp_hash_i);
    assign fail_inc      = fail_q + 4'd1;
    assign enter_lockout = hash_done && !hash_match && (fail_inc == FAIL_MAX);

    // State register and registered start pulse
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= S_IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
        end
    end

    // Next-state logic; the start pulse is raised only on the WAIT_RDY exit
    always_comb begin
        state_d = state_q;
        init_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pw_fire && (idx_q == LAST_IDX)) state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (hash_ready_i) begin
                    state_d = S_START_ACK;
                    init_d  = 1'b1;
                end
            end
            S_START_ACK: begin
                if (!hash_ready_i) state_d = S_WAIT_HASH;
            end
            S_WAIT_HASH: begin
                if (hash_valid_i) state_d = enter_lockout ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (lk_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Password collection; the message is wiped as soon as the engine returns a result
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            msg_q <= '0;
            idx_q <= '0;
        end else if (hash_done) begin
            msg_q <= '0;
        end else if (pw_fire) begin
            msg_q[{idx_q, 5'd0} +: 32] <= pw_data_i;
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // Lockout timer counts LOCKOUT_CYCLES-1 down to 0
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            lk_q <= '0;
        end else if (enter_lockout) begin
            lk_q <= LK_LOAD;
        end else if ((state_q == S_LOCKOUT) && (lk_q != '0)) begin
            lk_q <= lk_q - 1'b1;
        end
    end

    // Consecutive-mismatch counter, cleared by a match or at the end of lockout
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            fail_q <= '0;
        end else if (hash_done) begin
            fail_q <= hash_match ? 4'd0 : fail_inc;
        end else if ((state_q == S_LOCKOUT) && (lk_q == '0)) begin
            fail_q <= '0;
        end
    end

`ifdef DMI_UNLOCK_RELOCK_EN
    localparam logic [16:0] RL_LOAD = 17'(RELOCK_CYCLES - 1);
    logic [16:0] rl_q;

    // Relock timer: reloaded on every match, runs only while unlocked
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            rl_q <= '0;
        end else if (relock_i) begin
            rl_q <= '0;
        end else if (hash_done) begin
            rl_q <= hash_match ? RL_LOAD : 17'd0;
        end else if (unlock_q && (rl_q != '0)) begin
            rl_q <= rl_q - 17'd1;
        end
    end

    assign rl_expire = unlock_q && (rl_q == '0);
`else
    assign rl_expire = 1'b0;
`endif

    // Unlock flag; an explicit relock beats a same-cycle match
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            unlock_q <= 1'b0;
        end else if (relock_i) begin
            unlock_q <= 1'b0;
        end else if (hash_done) begin
            unlock_q <= hash_match;
        end else if (rl_expire) begin
            unlock_q <= 1'b0;
        end
    end

    assign pw_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_WAIT_RDY) || (state_q == S_START_ACK) ||
                         (state_q == S_WAIT_HASH);
    assign lockout_o   = (state_q == S_LOCKOUT);
    assign hash_init_o = init_q;
    assign message_o   = msg_q;
    assign unlock_o    = unlock_q;
    assign fail_cnt_o  = fail_q;

endmodule

// File: tb/tb_dmi_unlock_ctrl.sv
// tb/tb_dmi_unlock_ctrl.sv - directed self-checking bench for dmi_unlock_ctrl
module tb_dmi_unlock_ctrl;

    localparam logic [255:0] EXP_HASH =
        256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A55A5A5A5A_C0FFEE00DEADBEEF;

    logic         tck = 1'b0;
    logic         trst_n = 1'b0;
    logic         pw_valid = 1'b0;
    logic [31:0]  pw_data = '0;
    logic         pw_ready;
    logic         hash_init;
    logic         hash_ready = 1'b0;
    logic         hash_valid = 1'b0;
    logic [255:0] hash = '0;
    logic [255:0] exp_hash = EXP_HASH;
    logic [511:0] message;
    logic         relock = 1'b0;
    logic         unlock;
    logic         lockout;
    logic [3:0]   fail_cnt;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    dmi_unlock_ctrl #(
        .PW_WORDS      (2),
        .MAX_FAILS     (3),
        .LOCKOUT_CYCLES(1024),
        .RELOCK_CYCLES (16)
    ) dut (
        .tck_i       (tck),
        .trst_ni     (trst_n),
        .pw_valid_i  (pw_valid),
        .pw_data_i   (pw_data),
        .pw_ready_o  (pw_ready),
        .hash_init_o (hash_init),
        .hash_ready_i(hash_ready),
        .hash_valid_i(hash_valid),
        .hash_i      (hash),
        .exp_hash_i  (exp_hash),
        .message_o   (message),
        .relock_i    (relock),
        .unlock_o    (unlock),
        .lockout_o   (lockout),
        .fail_cnt_o  (fail_cnt),
        .busy_o      (busy)
    );

    always #5 tck = ~tck;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic send_pw(input logic [31:0] w0, input logic [31:0] w1);
        pw_valid = 1'b1;
        pw_data  = w0;
        step();
        pw_data  = w1;
        step();
        pw_valid = 1'b0;
    endtask

    // Engine model: ready high on entry, drops after the start pulse, then returns h
    task automatic run_hash(input logic [255:0] h, input logic rl, output int inits);
        inits = 0;
        step();
        if (hash_init) inits++;
        hash_ready = 1'b0;
        step();
        if (hash_init) inits++;
        hash_valid = 1'b1;
        hash       = h;
        relock     = rl;
        step();
        hash_valid = 1'b0;
        relock     = 1'b0;
        hash_ready = 1'b1;
    endtask

    initial begin
        int inits;
        int n;
        int seen;
        int busy_n;

        repeat (3) step();
        check_eq("rst_pw_ready", pw_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_unlock", unlock, 0);
        check_eq("rst_lockout", lockout, 0);
        check_eq("rst_fail", fail_cnt, 0);
        check_eq("rst_init", hash_init, 0);
        check_eq("rst_msg", message, 0);
        trst_n = 1'b1;
        step();

        // 1: matching attempt
        hash_ready = 1'b1;
        send_pw(32'hDEADBEEF, 32'h12345678);
        check_eq("t1_msg", message, 512'h12345678_DEADBEEF);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_pw_ready", pw_ready, 0);
        check_eq("t1_unlock_pre", unlock, 0);
        run_hash(EXP_HASH, 1'b0, inits);
        check_eq("t1_inits", inits, 1);
        check_eq("t1_unlock", unlock, 1);
        check_eq("t1_msg_clr", message, 0);
        check_eq("t1_busy_done", busy, 0);
        check_eq("t1_fail", fail_cnt, 0);

        // 2: three mismatches lead to a 1024-cycle lockout
        for (int k = 1; k <= 3; k++) begin
            send_pw(32'(k), ~32'(k));
            run_hash(~EXP_HASH, 1'b0, inits);
            check_eq($sformatf("t2_fail%0d", k), fail_cnt, k);
            check_eq($sformatf("t2_unlock%0d", k), unlock, 0);
        end
        check_eq("t2_lockout", lockout, 1);
        check_eq("t2_pw_ready_lk", pw_ready, 0);
        n = 0;
        seen = 0;
        while (lockout && n < 2000) begin
            n++;
            if (pw_ready) seen++;
            step();
        end
        check_eq("t2_lock_len", n, 1024);
        check_eq("t2_pw_ready_during", seen, 0);
        check_eq("t2_fail_clr", fail_cnt, 0);
        check_eq("t2_pw_ready_after", pw_ready, 1);

        // 3: engine busy for 10 cycles after the last word
        hash_ready = 1'b0;
        send_pw(32'hCAFEF00D, 32'h0BADC0DE);
        seen = 0;
        busy_n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (hash_init) seen++;
            if (busy) busy_n++;
        end
        check_eq("t3_no_init", seen, 0);
        check_eq("t3_busy", busy_n, 10);
        hash_ready = 1'b1;
        step();
        check_eq("t3_init", hash_init, 1);
        hash_ready = 1'b0;
        step();
        check_eq("t3_init_once", hash_init, 0);
        check_eq("t3_busy_wait", busy, 1);
        hash_valid = 1'b1;
        hash = EXP_HASH;
        step();
        hash_valid = 1'b0;
        hash_ready = 1'b1;
        check_eq("t3_unlock", unlock, 1);

        // 4: relock alone, then relock beats a same-cycle match
        relock = 1'b1;
        step();
        relock = 1'b0;
        check_eq("t4_relock", unlock, 0);
        send_pw(32'h1, 32'h2);
        run_hash(~EXP_HASH, 1'b0, inits);
        check_eq("t4_fail1", fail_cnt, 1);
        send_pw(32'h3, 32'h4);
        run_hash(EXP_HASH, 1'b1, inits);
        check_eq("t4_unlock", unlock, 0);
        check_eq("t4_fail", fail_cnt, 0);
        check_eq("t4_idle", pw_ready, 1);
        check_eq("t4_busy", busy, 0);

        // 5: reset during WAIT_HASH, then a stale matching result
        send_pw(32'h5, 32'h6);
        run_hash(EXP_HASH, 1'b0, inits);
        check_eq("t5_unlock_pre", unlock, 1);
        send_pw(32'h7, 32'h8);
        step();
        hash_ready = 1'b0;
        step();
        check_eq("t5_busy_pre", busy, 1);
        check_eq("t5_unlock_hold", unlock, 1);
        trst_n = 1'b0;
        #2;
        check_eq("t5_rst_unlock", unlock, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_pw_ready", pw_ready, 1);
        check_eq("t5_rst_msg", message, 0);
        step();
        trst_n = 1'b1;
        hash_ready = 1'b1;
        hash_valid = 1'b1;
        hash = EXP_HASH;
        step();
        hash_valid = 1'b0;
        check_eq("t5_stale_unlock", unlock, 0);
        check_eq("t5_stale_busy", busy, 0);
        check_eq("t5_stale_fail", fail_cnt, 0);
        check_eq("t5_stale_msg", message, 0);

        // 6: unlock duration with or without auto-relock
        send_pw(32'hAAAA5555, 32'h5555AAAA);
        check_eq("t6_msg", message, 512'h5555AAAA_AAAA5555);
        run_hash(EXP_HASH, 1'b0, inits);
        n = 0;
        while (unlock && n < 40) begin
            n++;
            step();
        end
`ifdef DMI_UNLOCK_RELOCK_EN
        check_eq("t6_unlock_len", n, 16);
`else
        check_eq("t6_unlock_len", n, 40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
